morse_rom_sender: RTL and testbench

//  Transmit-side counterpart of the Morse decoder: reads a message from the 256x8 synchronous

---
 rtl/morse_rom_sender_pkg.sv | 31 +++
 rtl/morse_unit_timer.sv | 35 +++
 rtl/morse_rom_sender.sv | 124 ++++++++++++
 tb/tb_morse_rom_sender.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/morse_rom_sender_pkg.sv
// Shared definitions for the Morse ROM sender: ROM byte fields, timing in units, FSM states.
package morse_rom_sender_pkg;

   localparam int unsigned LEN_MSB     = 7;
   localparam int unsigned LEN_LSB     = 5;
   localparam int unsigned ELEM_MSB    = 4;
   localparam int unsigned LEN_WORD    = 0;
   localparam int unsigned LEN_END_MIN = 6;

   localparam int unsigned DOT_UNITS  = 1;
   localparam int unsigned DASH_UNITS = 3;
   localparam int unsigned ELEM_GAP   = 1;
   localparam int unsigned CHAR_GAP   = 3;
   localparam int unsigned WORD_EXTRA = 4;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FETCH = 3'd1,
      ST_LATCH = 3'd2,
      ST_MARK  = 3'd3,
      ST_SPACE = 3'd4,
      ST_GAP   = 3'd5,
      ST_DONE  = 3'd6
   } state_t;

   // Tone length in units for one element bit (1 = dash).
   function automatic logic [2:0] elem_units(input logic is_dash);
      return is_dash ? 3'(DASH_UNITS) : 3'(DOT_UNITS);
   endfunction

endpackage

// File: rtl/morse_unit_timer.sv
// Morse unit timer: counts ticks per unit and pulses when the target unit count completes.
module morse_unit_timer #(
   parameter int unsigned UNIT_TICKS = 25_000_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       clear,
   input  logic [2:0] target,
   output logic       expired_c
);

   localparam int unsigned TICK_W = $clog2(UNIT_TICKS);
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(UNIT_TICKS - 1);

   logic [TICK_W-1:0] tick;
   logic [2:0]        units;
   logic              tick_last;

   assign tick_last = (tick == TICK_LAST);
   assign expired_c = tick_last && (units == (target - 3'd1));

   // Clear restarts both counters so a state lasts exactly target units from its first cycle.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         tick  <= '0;
         units <= '0;
      end else if (tick_last) begin
         tick  <= '0;
         units <= units + 3'd1;
      end else begin
         tick <= tick + TICK_W'(1);
      end
   end

endmodule

// File: rtl/morse_rom_sender.sv
// Reads encoded characters from a 1-cycle-latency ROM and keys them out as Morse timing.
module morse_rom_sender
   import morse_rom_sender_pkg::*;
#(
   parameter int unsigned UNIT_TICKS = 25_000_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [7:0] start_addr,
   output logic [7:0] rom_addr,
   input  logic [7:0] rom_data,
   output logic       key_out,
   output logic       busy,
   output logic       done
);

   state_t     state;
   logic [4:0] shreg;
   logic [2:0] remaining;
   logic [2:0] gap_units;
   logic [2:0] target_c;
   logic       timed_c;
   logic       clear_c;
   logic       expired_c;
   logic [2:0] len_c;

   assign len_c   = rom_data[LEN_MSB:LEN_LSB];
   assign timed_c = (state == ST_MARK) || (state == ST_SPACE) || (state == ST_GAP);
   assign clear_c = !timed_c || expired_c;

   always_comb begin
      target_c = 3'd1;
      case (state)
         ST_MARK:  target_c = elem_units(shreg[ELEM_MSB]);
         ST_SPACE: target_c = 3'(ELEM_GAP);
         ST_GAP:   target_c = gap_units;
         default:  target_c = 3'd1;
      endcase
   end

   morse_unit_timer #(.UNIT_TICKS(UNIT_TICKS)) u_timer (
      .clk       (clk),
      .reset     (reset),
      .clear     (clear_c),
      .target    (target_c),
      .expired_c (expired_c)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_IDLE;
         rom_addr  <= '0;
         key_out   <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         shreg     <= '0;
         remaining <= '0;
         gap_units <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  rom_addr <= start_addr;
                  busy     <= 1'b1;
                  state    <= ST_FETCH;
               end
            end
            ST_FETCH: state <= ST_LATCH;
            ST_LATCH: begin
               if (len_c >= 3'(LEN_END_MIN)) begin
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= ST_DONE;
               end else if (len_c == 3'(LEN_WORD)) begin
                  gap_units <= 3'(WORD_EXTRA);
                  state     <= ST_GAP;
               end else begin
                  shreg     <= rom_data[ELEM_MSB:0];
                  remaining <= len_c;
                  key_out   <= 1'b1;
                  state     <= ST_MARK;
               end
            end
            ST_MARK: begin
               if (expired_c) begin
                  key_out <= 1'b0;
                  if (remaining == 3'd1) begin
                     gap_units <= 3'(CHAR_GAP);
                     state     <= ST_GAP;
                  end else begin
                     remaining <= remaining - 3'd1;
                     state     <= ST_SPACE;
                  end
               end
            end
            ST_SPACE: begin
               if (expired_c) begin
                  shreg   <= {shreg[ELEM_MSB-1:0], 1'b0};
                  key_out <= 1'b1;
                  state   <= ST_MARK;
               end
            end
            // The last ROM address ends the message rather than wrapping to 0x00.
            ST_GAP: begin
               if (expired_c) begin
                  if (rom_addr == 8'hFF) begin
                     done  <= 1'b1;
                     busy  <= 1'b0;
                     state <= ST_DONE;
                  end else begin
                     rom_addr <= rom_addr + 8'd1;
                     state    <= ST_FETCH;
                  end
               end
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_morse_rom_sender.sv
// Bench for morse_rom_sender: per-cycle comparison against a unit-arithmetic model of the message.
module tb_morse_rom_sender;

   localparam int unsigned UT = 4;

   logic       clk;
   logic       reset;
   logic       start;
   logic [7:0] start_addr;
   logic [7:0] rom_addr;
   logic [7:0] rom_data;
   logic       key_out;
   logic       busy;
   logic       done;

   logic [7:0]  rom [256];
   logic [10:0] exp_q [$];
   int          checks;
   int          passed;
   int          fails;

   morse_rom_sender #(.UNIT_TICKS(UT)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .start_addr (start_addr),
      .rom_addr   (rom_addr),
      .rom_data   (rom_data),
      .key_out    (key_out),
      .busy       (busy),
      .done       (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_ff @(posedge clk) rom_data <= rom[rom_addr];

   task automatic check(input string tag, input int idx, input logic [31:0] obs,
                        input logic [31:0] expv);
      checks++;
      assert (obs === expv) passed++;
      else begin
         fails++;
         $error("FAIL %s[%0d] observed=%h expected=%h", tag, idx, obs, expv);
      end
   endtask

   // Append n cycles of {rom_addr, key, busy, done}.
   task automatic push(input int n, input logic [7:0] a, input logic k, input logic b,
                       input logic d);
      for (int i = 0; i < n; i++) exp_q.push_back({a, k, b, d});
   endtask

   // Expected trace starting the cycle after the accepted start edge.
   task automatic build(input logic [7:0] sa);
      logic [7:0] a;
      logic [7:0] by;
      int         len;
      exp_q.delete();
      a = sa;
      forever begin
         push(2, a, 1'b0, 1'b1, 1'b0);
         by  = rom[a];
         len = int'(by[7:5]);
         if (len >= 6) break;
         if (len == 0) begin
            push(4 * UT, a, 1'b0, 1'b1, 1'b0);
         end else begin
            for (int i = 0; i < len; i++) begin
               push(by[4-i] ? 3 * UT : UT, a, 1'b1, 1'b1, 1'b0);
               if (i < len - 1) push(UT, a, 1'b0, 1'b1, 1'b0);
            end
            push(3 * UT, a, 1'b0, 1'b1, 1'b0);
         end
         if (a == 8'hFF) break;
         a = a + 8'd1;
      end
      push(1, a, 1'b0, 1'b0, 1'b1);
      push(1, a, 1'b0, 1'b0, 1'b0);
   endtask

   // Send from sa; optionally pulse start with alt_addr at cycle alt_at (-2 = the done cycle).
   task automatic run_msg(input string tag, input logic [7:0] sa, input int alt_at,
                          input logic [7:0] alt_addr, output int hi);
      int n;
      int at;
      build(sa);
      n  = exp_q.size();
      at = (alt_at == -2) ? n - 2 : alt_at;
      hi = 0;
      @(negedge clk);
      start      = 1'b1;
      start_addr = sa;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < n; i++) begin
         check(tag, i, 32'({rom_addr, key_out, busy, done}), 32'(exp_q[i]));
         hi    += int'(key_out);
         start  = 1'b0;
         if (i == at) begin
            start      = 1'b1;
            start_addr = alt_addr;
         end
         @(posedge clk); #1;
      end
      start = 1'b0;
   endtask

   int hi;

   initial begin
      checks = 0; passed = 0; fails = 0;
      reset = 1'b1; start = 1'b0; start_addr = 8'h00;
      for (int a = 0; a < 256; a++) rom[a] = 8'hE0;
      repeat (2) @(posedge clk);
      #1;
      check("reset", 0, 32'({rom_addr, key_out, busy, done}), 32'h0);
      reset = 1'b0;
      @(posedge clk); #1;
      check("idle", 0, 32'({rom_addr, key_out, busy, done}), 32'h0);

      // 'E' then end
      rom[0] = 8'h20; rom[1] = 8'hE0;
      run_msg("e", 8'h00, -1, 8'h00, hi);
      check("e_high", 0, 32'(hi), 32'(4));

      // 'A'
      rom[0] = 8'h48; rom[1] = 8'hE0;
      run_msg("a", 8'h00, -1, 8'h00, hi);
      check("a_high", 0, 32'(hi), 32'(16));

      // 'E' word-space 'T'
      rom[0] = 8'h20; rom[1] = 8'h00; rom[2] = 8'h30; rom[3] = 8'hE0;
      run_msg("e_sp_t", 8'h00, -1, 8'h00, hi);
      check("e_sp_t_high", 0, 32'(hi), 32'(16));

      // Last address: no wrap to 0x00
      rom[8'hFF] = 8'h20;
      run_msg("top", 8'hFF, -1, 8'h00, hi);
      check("top_high", 0, 32'(hi), 32'(4));

      // Reset mid-dash
      rom[8'h10] = 8'h30; rom[8'h11] = 8'hE0;
      build(8'h10);
      @(negedge clk);
      start = 1'b1; start_addr = 8'h10;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < 7; i++) begin
         check("pre_rst", i, 32'({rom_addr, key_out, busy, done}), 32'(exp_q[i]));
         @(posedge clk); #1;
      end
      reset = 1'b1;
      @(posedge clk); #1;
      check("mid_rst", 0, 32'({rom_addr, key_out, busy, done}), 32'h0);
      reset = 1'b0;
      for (int i = 0; i < 20; i++) begin
         check("post_rst", i, 32'({rom_addr, key_out, busy, done}), 32'h0);
         @(posedge clk); #1;
      end
      run_msg("after_rst", 8'h10, -1, 8'h00, hi);
      check("after_rst_high", 0, 32'(hi), 32'(12));

      // Second start while busy goes unheeded
      rom[8'h40] = 8'h3F; rom[8'h41] = 8'hE0;
      rom[0] = 8'h48; rom[1] = 8'hE0;
      run_msg("busy_start", 8'h00, 5, 8'h40, hi);
      check("busy_start_high", 0, 32'(hi), 32'(16));

      // Start during the done cycle is ignored
      run_msg("done_start", 8'h00, -2, 8'h40, hi);
      repeat (3) begin
         check("done_start_idle", 0, 32'({key_out, busy, done}), 32'h0);
         @(posedge clk); #1;
      end

      // Randomised messages
      for (int m = 0; m < 6; m++) begin
         logic [7:0] base;
         int         nch;
         base = 8'($urandom_range(32, 200));
         nch  = int'($urandom_range(1, 6));
         for (int c = 0; c < nch; c++) begin
            if ($urandom_range(0, 6) == 0)
               rom[base + 8'(c)] = {3'd0, 5'($urandom_range(0, 31))};
            else
               rom[base + 8'(c)] = {3'($urandom_range(1, 5)), 5'($urandom_range(0, 31))};
         end
         rom[base + 8'(nch)] = {($urandom_range(0, 1) == 0) ? 3'd6 : 3'd7,
                                5'($urandom_range(0, 31))};
         run_msg("rand", base, -1, 8'h00, hi);
      end

      // Random characters running off the top of the ROM
      for (int a = 8'hFB; a < 256; a++)
         rom[a] = {3'($urandom_range(1, 5)), 5'($urandom_range(0, 31))};
      run_msg("rand_top", 8'hFB, -1, 8'h00, hi);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
